// File: rtl/serial_adder_subtractor_pkg.sv
// Shared definitions for the serial SAP datapath blocks: state encoding and
// parameter legality helpers.
package serial_adder_subtractor_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_t;

    // Slice width must be non-zero and tile the word exactly.
    function automatic bit slice_divides(input int unsigned width, input int unsigned slice);
        return (slice != 0) && ((width % slice) == 0);
    endfunction

endpackage

// File: rtl/serial_adder_subtractor_slice_adder.sv
// SLICE-bit ripple-carry adder (generalised 74LS83), also exposing the carry
// into its top bit so the caller can derive signed overflow.
module serial_adder_subtractor_slice_adder #(
    parameter int unsigned SLICE = 4
) (
    input  logic [SLICE-1:0] A,
    input  logic [SLICE-1:0] B,
    input  logic             C0,
    output logic [SLICE-1:0] S,
    output logic             C4,
    output logic             c_msb
);

    logic [SLICE:0] c;

    always_comb begin
        c    = '0;
        S    = '0;
        c[0] = C0;
        for (int i = 0; i < SLICE; i++) begin
            S[i]   = A[i] ^ B[i] ^ c[i];
            c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
        end
    end

    assign C4    = c[SLICE];
    assign c_msb = c[SLICE-1];

endmodule

// File: rtl/serial_adder_subtractor.sv
// Multi-cycle adder/subtractor for the SAP bus: one SLICE-bit digit per clock
// through a shared slice adder, result and C/Z/N/V committed together.
module serial_adder_subtractor
    import serial_adder_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SLICE = 4
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [WIDTH-1:0] a_input,
    input  logic [WIDTH-1:0] b_input,
    input  logic             S_U,
    input  logic             start,
    input  logic             E_U,
    output logic             busy,
    output logic             done,
    output logic             result_valid,
    output logic [WIDTH-1:0] bus_output,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v
);

    localparam int unsigned NUM_SLICES = WIDTH / SLICE;
    localparam int unsigned IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    if (!slice_divides(WIDTH, SLICE)) begin : g_bad_slice
        $error("serial_adder_subtractor: SLICE must divide WIDTH");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, shadow_q, shadow_d, result_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q, valid_q;
    logic             flag_c_q, flag_z_q, flag_n_q, flag_v_q;
    logic             accept, last_slice;
    logic [SLICE-1:0] slice_a, slice_b, slice_s;
    logic             slice_c4, slice_cmsb;

    assign last_slice = (idx_q == IDX_W'(NUM_SLICES - 1));

    always_comb begin
        slice_a  = a_q[idx_q*SLICE +: SLICE];
        slice_b  = b_q[idx_q*SLICE +: SLICE];
        shadow_d = shadow_q;
        shadow_d[idx_q*SLICE +: SLICE] = slice_s;
    end

    serial_adder_subtractor_slice_adder #(
        .SLICE (SLICE)
    ) u_slice_adder (
        .A     (slice_a),
        .B     (slice_b),
        .C0    (carry_q),
        .S     (slice_s),
        .C4    (slice_c4),
        .c_msb (slice_cmsb)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    accept  = 1'b1;
                end
            end
            StRun: begin
                if (last_slice) state_d = StDone;
            end
            StDone: begin
                state_d = start ? StRun : StIdle;
                accept  = start;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            shadow_q <= '0;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            valid_q  <= 1'b0;
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
            flag_v_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                // Subtract folds into add: invert B here, +1 via the initial carry.
                a_q     <= a_input;
                b_q     <= b_input ^ {WIDTH{S_U}};
                carry_q <= S_U;
                idx_q   <= '0;
            end else if (state_q == StRun) begin
                shadow_q <= shadow_d;
                carry_q  <= slice_c4;
                idx_q    <= last_slice ? '0 : idx_q + 1'b1;
                // Commit on the last slice edge so the result is visible throughout DONE.
                if (last_slice) begin
                    result_q <= shadow_d;
                    valid_q  <= 1'b1;
                    flag_c_q <= slice_c4;
                    flag_z_q <= (shadow_d == '0);
                    flag_n_q <= shadow_d[WIDTH-1];
                    flag_v_q <= slice_cmsb ^ slice_c4;
                end
            end
        end
    end

    assign busy         = (state_q == StRun);
    assign done         = (state_q == StDone);
    assign result_valid = valid_q;
    assign flag_c       = flag_c_q;
    assign flag_z       = flag_z_q;
    assign flag_n       = flag_n_q;
    assign flag_v       = flag_v_q;

    for (genvar g = 0; g < NUM_SLICES; g++) begin : g_bus_buf
        assign bus_output[g*SLICE +: SLICE] = (E_U && valid_q) ? result_q[g*SLICE +: SLICE]
                                                                : {SLICE{1'bz}};
    end

endmodule

// File: tb/tb_serial_adder_subtractor.sv
// Directed bench for serial_adder_subtractor at WIDTH=8 and WIDTH=12 (SLICE=4).
module tb_serial_adder_subtractor;

    logic        CLK, CLR;
    logic [7:0]  a8, b8;
    logic        su8, start8, eu8;
    wire  [7:0]  bus8;
    logic        busy8, done8, rv8, c8, z8, n8, v8;

    logic [11:0] a12, b12;
    logic        su12, start12, eu12;
    wire  [11:0] bus12;
    logic        busy12, done12, rv12, c12, z12, n12, v12;

    int checks   = 0;
    int failures = 0;

    serial_adder_subtractor #(.WIDTH(8), .SLICE(4)) dut8 (
        .CLK(CLK), .CLR(CLR), .a_input(a8), .b_input(b8), .S_U(su8), .start(start8),
        .E_U(eu8), .busy(busy8), .done(done8), .result_valid(rv8), .bus_output(bus8),
        .flag_c(c8), .flag_z(z8), .flag_n(n8), .flag_v(v8)
    );

    serial_adder_subtractor #(.WIDTH(12), .SLICE(4)) dut12 (
        .CLK(CLK), .CLR(CLR), .a_input(a12), .b_input(b12), .S_U(su12), .start(start12),
        .E_U(eu12), .busy(busy12), .done(done12), .result_valid(rv12), .bus_output(bus12),
        .flag_c(c12), .flag_z(z12), .flag_n(n12), .flag_v(v12)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Launch an 8-bit op and advance to the DONE cycle (or give up).
    task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic su,
                          output int busy_cycles, output bit got_done);
        a8 = a; b8 = b; su8 = su; start8 = 1'b1;
        step();
        start8 = 1'b0;
        busy_cycles = 0;
        got_done = 1'b0;
        for (int i = 0; i < 10 && !got_done; i++) begin
            if (done8) got_done = 1'b1;
            else begin
                if (busy8) busy_cycles++;
                step();
            end
        end
    endtask

    task automatic test_reset();
        CLR = 1'b1;
        a8 = '0; b8 = '0; su8 = 0; start8 = 0; eu8 = 1;
        a12 = '0; b12 = '0; su12 = 0; start12 = 0; eu12 = 1;
        step(); step();
        checks++;
        if ({busy8, done8, rv8} !== 3'b000) begin
            failures++; $display("FAIL reset_ctrl: got %b want 000", {busy8, done8, rv8});
        end
        checks++;
        if ({c8, z8, n8, v8} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags: got %b want 0000", {c8, z8, n8, v8});
        end
        // A 2-state simulator resolves an undriven bus to 0.
        checks++;
        if (!(bus8 === 8'hzz || bus8 === 8'h00)) begin
            failures++; $display("FAIL reset_bus: got %h want zz", bus8);
        end
        CLR = 1'b0;
        step();
    endtask

    task automatic test_add();
        int  bc;
        bit  gd;
        do_op8(8'd128, 8'd32, 1'b0, bc, gd);
        checks++;
        if (!gd || bc != 2) begin
            failures++; $display("FAIL add_latency: done=%0d busy_cycles=%0d want 1/2", gd, bc);
        end
        checks++;
        if (bus8 !== 8'd160 || rv8 !== 1'b1) begin
            failures++; $display("FAIL add_bus: got %0d rv=%b want 160 rv=1", bus8, rv8);
        end
        checks++;
        if ({c8, z8, n8, v8} !== 4'b0010) begin
            failures++; $display("FAIL add_flags: got %b want 0010", {c8, z8, n8, v8});
        end
        step();
        checks++;
        if ({busy8, done8} !== 2'b00) begin
            failures++; $display("FAIL add_pulse: busy/done got %b want 00", {busy8, done8});
        end
    endtask

    task automatic test_subtract();
        int  bc;
        bit  gd;
        do_op8(8'd200, 8'd32, 1'b1, bc, gd);
        checks++;
        if (!gd || bus8 !== 8'd168 || {c8, z8, n8, v8} !== 4'b1010) begin
            failures++;
            $display("FAIL sub_200_32: done=%0d bus=%0d flags=%b want 1/168/1010",
                     gd, bus8, {c8, z8, n8, v8});
        end
        step();
        do_op8(8'd32, 8'd128, 1'b1, bc, gd);
        checks++;
        if (!gd || bus8 !== 8'd160 || {c8, z8, n8, v8} !== 4'b0011) begin
            failures++;
            $display("FAIL sub_32_128: done=%0d bus=%0d flags=%b want 1/160/0011",
                     gd, bus8, {c8, z8, n8, v8});
        end
        step();
    endtask

    task automatic test_overflow_zero();
        int  bc;
        bit  gd;
        do_op8(8'h80, 8'h80, 1'b0, bc, gd);
        checks++;
        if (!gd || bus8 !== 8'h00 || {c8, z8, n8, v8} !== 4'b1101) begin
            failures++;
            $display("FAIL ovf_zero: done=%0d bus=%h flags=%b want 1/00/1101",
                     gd, bus8, {c8, z8, n8, v8});
        end
        step();
        eu8 = 1'b0;
        #1;
        checks++;
        if (!(bus8 === 8'hzz || bus8 === 8'h00) || {c8, z8, n8, v8} !== 4'b1101) begin
            failures++; $display("FAIL ovf_eu_off: bus=%h flags=%b want zz/1101", bus8, {c8, z8, n8, v8});
        end
        eu8 = 1'b1;
        step();
    endtask

    task automatic test_bus_enable();
        int  bc;
        bit  gd;
        do_op8(8'h12, 8'h34, 1'b0, bc, gd);
        step();
        checks++;
        if (bus8 !== 8'h46 || {c8, z8, n8, v8} !== 4'b0000) begin
            failures++; $display("FAIL en_on: bus=%h flags=%b want 46/0000", bus8, {c8, z8, n8, v8});
        end
        eu8 = 1'b0;
        step();
        checks++;
        if (!(bus8 === 8'hzz || bus8 === 8'h00)) begin
            failures++; $display("FAIL en_off: bus=%h want zz", bus8);
        end
        eu8 = 1'b1;
        #1;
        checks++;
        if (bus8 !== 8'h46 || rv8 !== 1'b1) begin
            failures++; $display("FAIL en_restore: bus=%h rv=%b want 46/1", bus8, rv8);
        end
    endtask

    task automatic test_start_mid_run();
        int dones = 0;
        a8 = 8'd5; b8 = 8'd3; su8 = 1'b0; start8 = 1'b1;
        step();
        a8 = 8'd100; su8 = 1'b1;
        step();
        start8 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (done8) dones++;
            step();
        end
        checks++;
        if (dones != 1 || bus8 !== 8'd8) begin
            failures++; $display("FAIL mid_run_start: dones=%0d bus=%0d want 1/8", dones, bus8);
        end
    endtask

    task automatic test_back_to_back();
        a8 = 8'd10; b8 = 8'd20; su8 = 1'b0; start8 = 1'b1;
        step(); step(); step();
        checks++;
        if (done8 !== 1'b1 || bus8 !== 8'd30) begin
            failures++; $display("FAIL b2b_first: done=%b bus=%0d want 1/30", done8, bus8);
        end
        a8 = 8'd50; b8 = 8'd7; su8 = 1'b1;
        step();
        start8 = 1'b0;
        checks++;
        if ({busy8, done8} !== 2'b10 || bus8 !== 8'd30) begin
            failures++;
            $display("FAIL b2b_no_idle: busy/done=%b bus=%0d want 10/30", {busy8, done8}, bus8);
        end
        step(); step();
        checks++;
        if (done8 !== 1'b1 || bus8 !== 8'd43 || {c8, z8, n8, v8} !== 4'b1000) begin
            failures++;
            $display("FAIL b2b_second: done=%b bus=%0d flags=%b want 1/43/1000",
                     done8, bus8, {c8, z8, n8, v8});
        end
        step();
    endtask

    task automatic test_clr_mid_run();
        a8 = 8'h11; b8 = 8'h22; su8 = 1'b0; start8 = 1'b1;
        step();
        start8 = 1'b0;
        #2;
        CLR = 1'b1;
        #1;
        checks++;
        if ({busy8, done8, rv8} !== 3'b000 || {c8, z8, n8, v8} !== 4'b0000) begin
            failures++;
            $display("FAIL clr_mid_run: ctrl=%b flags=%b want 000/0000",
                     {busy8, done8, rv8}, {c8, z8, n8, v8});
        end
        checks++;
        if (!(bus8 === 8'hzz || bus8 === 8'h00)) begin
            failures++; $display("FAIL clr_bus: bus=%h want zz", bus8);
        end
        CLR = 1'b0;
        step(); step(); step();
        checks++;
        if ({busy8, done8, rv8} !== 3'b000) begin
            failures++; $display("FAIL clr_stays_idle: ctrl=%b want 000", {busy8, done8, rv8});
        end
    endtask

    task automatic test_width12();
        int  bc = 0;
        bit  gd = 1'b0;
        bit  held = 1'b1;
        a12 = 12'h123; b12 = 12'h456; su12 = 1'b0; start12 = 1'b1;
        step();
        start12 = 1'b0;
        for (int i = 0; i < 10 && !done12; i++) step();
        checks++;
        if (done12 !== 1'b1 || bus12 !== 12'h579) begin
            failures++; $display("FAIL w12_prior: done=%b bus=%h want 1/579", done12, bus12);
        end
        step();
        a12 = 12'hFFF; b12 = 12'h001; start12 = 1'b1;
        step();
        start12 = 1'b0;
        for (int i = 0; i < 10 && !gd; i++) begin
            if (done12) gd = 1'b1;
            else begin
                if (busy12) bc++;
                if (bus12 !== 12'h579) held = 1'b0;
                step();
            end
        end
        checks++;
        if (!gd || bc != 3) begin
            failures++; $display("FAIL w12_latency: done=%0d busy_cycles=%0d want 1/3", gd, bc);
        end
        checks++;
        if (!held) begin
            failures++; $display("FAIL w12_hold: bus changed during RUN, want 579 held");
        end
        checks++;
        if (bus12 !== 12'h000 || {c12, z12, n12, v12} !== 4'b1100) begin
            failures++;
            $display("FAIL w12_wrap: bus=%h flags=%b want 000/1100", bus12, {c12, z12, n12, v12});
        end
        step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_subtract();
        test_overflow_zero();
        test_bus_enable();
        test_start_mid_run();
        test_back_to_back();
        test_clr_mid_run();
        test_width12();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder_subtractor.md
Name: serial_adder_subtractor

Overview:
- Parametrised, multi-cycle successor to the SAP-1 adder/subtractor.
- Operands are captured on a start strobe. The sum or difference is computed one SLICE-bit digit per clock through a single shared slice adder, with the carry rippling through a register.
- Result and status flags (C, Z, N, V) are committed together on completion.
- The result drives the shared W bus through a tri-state gate under E_U, so it drops into the SAP bus in place of the combinational unit.

Parameters:
- WIDTH, 8, operand/result width in bits.
- SLICE, 4, bits processed per clock. Must divide WIDTH; elaboration error otherwise.
- NUM_SLICES, WIDTH/SLICE, derived (localparam), cycles per operation.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- CLR  input  1  reset, asynchronous, active-high.
- a_input  input  WIDTH  minuend/addend (accumulator side).
- b_input  input  WIDTH  subtrahend/addend (B register side).
- S_U  input  1  0 = add, 1 = subtract (A + ~B + 1); sampled with start.
- start  input  1  request operation; accepted only in IDLE or DONE.
- E_U  input  1  bus enable for result.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse in the cycle after the last slice is computed.
- result_valid  output  1  a committed result exists since last reset.
- bus_output  output  WIDTH  committed result when E_U && result_valid, else all Z.
- flag_c  output  1  carry out of MSB (subtract: 1 = no borrow).
- flag_z  output  1  committed result == 0.
- flag_n  output  1  committed result MSB.
- flag_v  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (CLR high, any time including mid-RUN):
  - state = IDLE; busy = 0, done = 0, result_valid = 0.
  - Result register and all flags = 0; slice index = 0; bus_output = Z.
- States: IDLE, RUN, DONE.
- IDLE, start = 1 at an edge:
  - Latch a_input, b_input ^ {WIDTH{S_U}} and S_U into operand registers.
  - carry register = S_U; slice index = 0; go to RUN.
- RUN, each edge:
  - Slice adder sums operand slice[index] + carry register.
  - Sum goes into a shadow register at bits [index*SLICE +: SLICE]; carry register = slice carry out; index++.
  - On the last slice, also capture carry-into-MSB for V.
  - After NUM_SLICES edges, go to DONE.
- Latency: start sampled at edge 0 -> done high after edge NUM_SLICES (e.g. 2 cycles at WIDTH=8, SLICE=4).
- DONE, one cycle only, on entry:
  - Shadow copies to committed result; flags update; result_valid = 1; done = 1.
  - Next state = RUN if start = 1 (new operands latched as in IDLE), else IDLE.
- start while in RUN: ignored, no queuing; operand and mode inputs changing during RUN have no effect.
- Committed result and flags hold their values through a following RUN; bus contents change only at DONE entry.
- E_U is purely combinational on the output; toggling it never disturbs state.
- All arithmetic is modulo 2^WIDTH. The carry out of the final slice is not added back.

Decomposition:
- Shared package: state encoding constants (IDLE, RUN, DONE) and a SLICE-divides-WIDTH check macro, reused by later SAP-2 datapath blocks.
- Sub-module slice_adder:
  - Parametrised SLICE-bit ripple adder (generalised 74LS83): ports A, B, C0 -> S, C4, plus carry into top bit for V.
  - Instantiated once.
- Tri-state output: reuse the existing 74LS126-style buffer per slice, or a generate loop of them.

Test Plan (WIDTH=8, SLICE=4 unless noted):
- Add: a=128, b=32, S_U=0, start one cycle, E_U=1.
  - busy for 2 cycles, then done pulse.
  - bus=160, C=0, Z=0, N=1, V=0.
- Subtract: a=200, b=32, S_U=1 -> bus=168, C=1, N=1, V=0.
  - Then a=32, b=128, S_U=1 -> bus=160, C=0, N=1, V=1.
- Overflow and zero: a=0x80, b=0x80, S_U=0 -> bus=0x00, C=1, Z=1, N=0, V=1.
  - Then E_U=0 -> bus all Z, flags unchanged.
- Control:
  - start re-asserted mid-RUN is ignored; exactly one done.
  - start held through DONE begins the next op with no IDLE cycle.
  - CLR asserted mid-RUN (between edges) -> immediate IDLE, result_valid=0, bus Z, flags 0.
- WIDTH=12, SLICE=4: a=0xFFF, b=0x001, S_U=0 -> done after 3 cycles, bus=0x000, C=1, Z=1, V=0.
  - During that RUN, bus still shows the previous committed result.
